// File: rtl/btn_conditioner.sv
// Two-channel push-button conditioner: synchronizes, debounces and edge-detects
// raw buttons A and B for the hockey game block.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable synchronized samples to accept a change (2..65535)
//   REPEAT_DELAY    - hold cycles from the press pulse to the first auto-repeat pulse
//   REPEAT_PERIOD   - cycles between later auto-repeat pulses
// Optional feature: define BTN_AUTOREPEAT_EN to enable auto-repeat while a button is held.
//
// Ports:
//   clk                    - clock, rising edge
//   rst                    - asynchronous reset, active low
//   BTNA_raw, BTNB_raw     - asynchronous button levels, high = pressed
//   BTNA, BTNB             - registered one-cycle press pulses
//   BTNA_level, BTNB_level - registered debounced levels
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_PERIOD   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic BTNA_raw,
    input  logic BTNB_raw,
    output logic BTNA,
    output logic BTNB,
    output logic BTNA_level,
    output logic BTNB_level
);

    localparam int unsigned NCH = 2;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT_LAST  = RPT_W'(REPEAT_PERIOD - 1);
`else
    // Repeat timing parameters have no hardware in this build.
    logic unused_rpt;
    assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [NCH-1:0] raw;
    logic [NCH-1:0] pulse;
    logic [NCH-1:0] level;

    assign raw        = {BTNB_raw, BTNA_raw};
    assign BTNA       = pulse[0];
    assign BTNB       = pulse[1];
    assign BTNA_level = level[0];
    assign BTNB_level = level[1];

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic             sync1;
        logic             s;
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             pulse_r;
        logic             level_r;
`ifdef BTN_AUTOREPEAT_EN
        logic [RPT_W-1:0] rcnt;
        logic             rfirst;
`endif

        assign pulse[ch] = pulse_r;
        assign level[ch] = level_r;

        // 2-flop synchronizer; s is the debounce sample
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync1 <= 1'b0;
                s     <= 1'b0;
            end else begin
                sync1 <= raw[ch];
                s     <= sync1;
            end
        end

        // Debounce FSM with registered pulse and level
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state   <= IDLE;
                cnt     <= '0;
                pulse_r <= 1'b0;
                level_r <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rcnt    <= '0;
                rfirst  <= 1'b1;
`endif
            end else begin
                pulse_r <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                // Hold timer only runs while the accepted press is still held
                if (!(state == PRESSED && s)) begin
                    rcnt   <= '0;
                    rfirst <= 1'b1;
                end
`endif
                case (state)
                    IDLE: begin
                        if (s) begin
                            state <= PRESS_WAIT;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= PRESSED;
                            cnt     <= '0;
                            pulse_r <= 1'b1;
                            level_r <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (!s) begin
                            state <= RELEASE_WAIT;
                            cnt   <= CNT_W'(1);
                        end
`ifdef BTN_AUTOREPEAT_EN
                        else if (rcnt == (rfirst ? RPT_FIRST_LAST : RPT_NEXT_LAST)) begin
                            pulse_r <= 1'b1;
                            rcnt    <= '0;
                            rfirst  <= 1'b0;
                        end else begin
                            rcnt <= rcnt + RPT_W'(1);
                        end
`endif
                    end
                    RELEASE_WAIT: begin
                        if (s) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            level_r <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

    localparam int unsigned D      = 4;
    localparam int unsigned RDELAY = 16;
    localparam int unsigned RPER   = 8;
    localparam int LAT = int'(D) + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic BTNA_raw = 1'b0;
    logic BTNB_raw = 1'b0;
    logic BTNA, BTNB, BTNA_level, BTNB_level;

    int cyc    = 0;
    int checks = 0;
    int fails  = 0;

    // Scoreboard: expected pulse edges pushed at stimulus, observed edges recorded at sample
    int exp_q[2][$];
    int obs_q[2][$];

    btn_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RDELAY),
        .REPEAT_PERIOD(RPER)
    ) dut (
        .clk(clk),
        .rst(rst),
        .BTNA_raw(BTNA_raw),
        .BTNB_raw(BTNB_raw),
        .BTNA(BTNA),
        .BTNB(BTNB),
        .BTNA_level(BTNA_level),
        .BTNB_level(BTNB_level)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, sample 1ns later, log any pulses with their edge number
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (BTNA === 1'b1) obs_q[0].push_back(cyc);
            if (BTNB === 1'b1) obs_q[1].push_back(cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        BTNA_raw = 1'b1;
        BTNB_raw = 1'b1;
        step(3);
        checks++;
        if ({BTNA, BTNB, BTNA_level, BTNB_level} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_outputs: got %b, expected 0000", {BTNA, BTNB, BTNA_level, BTNB_level});
        end
        BTNA_raw = 1'b0;
        BTNB_raw = 1'b0;
        step(2);
        rst = 1'b1;
        step(8);
        for (int ch = 0; ch < 2; ch++) begin
            checks++;
            if (obs_q[ch].size() != exp_q[ch].size()) begin
                fails++;
                $display("FAIL reset ch%0d pulse_count: got %0d, expected %0d", ch, obs_q[ch].size(), exp_q[ch].size());
            end
            exp_q[ch].delete();
            obs_q[ch].delete();
        end
    endtask

    task automatic test_clean_press();
        int c, r, e, o;
        c = cyc;
        BTNA_raw = 1'b1;
        exp_q[0].push_back(c + LAT);
        step(LAT - 1);
        checks++;
        if (BTNA_level !== 1'b0) begin
            fails++;
            $display("FAIL clean level_before: got %b, expected 0", BTNA_level);
        end
        step(1);
        checks++;
        if (BTNA_level !== 1'b1 || BTNA !== 1'b1) begin
            fails++;
            $display("FAIL clean pulse_and_level: got pulse=%b level=%b, expected 1 1", BTNA, BTNA_level);
        end
        step(1);
        checks++;
        if (BTNA !== 1'b0 || BTNA_level !== 1'b1) begin
            fails++;
            $display("FAIL clean after_pulse: got pulse=%b level=%b, expected 0 1", BTNA, BTNA_level);
        end
        step(30 - LAT - 1);
        r = cyc;
        BTNA_raw = 1'b0;
        step(LAT - 1);
        checks++;
        if (BTNA_level !== 1'b1) begin
            fails++;
            $display("FAIL clean level_hold: got %b, expected 1 at edge %0d", BTNA_level, cyc - r);
        end
        step(1);
        checks++;
        if (BTNA_level !== 1'b0) begin
            fails++;
            $display("FAIL clean level_release: got %b, expected 0", BTNA_level);
        end
        step(4);
        for (int ch = 0; ch < 2; ch++) begin
            checks++;
            if (obs_q[ch].size() != exp_q[ch].size()) begin
                fails++;
                $display("FAIL clean ch%0d pulse_count: got %0d, expected %0d", ch, obs_q[ch].size(), exp_q[ch].size());
            end
            while (exp_q[ch].size() > 0 && obs_q[ch].size() > 0) begin
                e = exp_q[ch].pop_front();
                o = obs_q[ch].pop_front();
                checks++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL clean ch%0d pulse_edge: got %0d, expected %0d", ch, o, e);
                end
            end
            exp_q[ch].delete();
            obs_q[ch].delete();
        end
    endtask

    task automatic test_glitch();
        bit lvl_seen;
        lvl_seen = 1'b0;
        BTNA_raw = 1'b1;
        step(2);
        BTNA_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (BTNA_level !== 1'b0) lvl_seen = 1'b1;
        end
        checks++;
        if (lvl_seen) begin
            fails++;
            $display("FAIL glitch level: got 1 at some edge, expected 0 throughout");
        end
        for (int ch = 0; ch < 2; ch++) begin
            checks++;
            if (obs_q[ch].size() != exp_q[ch].size()) begin
                fails++;
                $display("FAIL glitch ch%0d pulse_count: got %0d, expected %0d", ch, obs_q[ch].size(), exp_q[ch].size());
            end
            exp_q[ch].delete();
            obs_q[ch].delete();
        end
    endtask

    task automatic test_bounce();
        int e, o;
        for (int i = 0; i < 10; i++) begin
            BTNA_raw = ~BTNA_raw;
            step(1);
        end
        BTNA_raw = 1'b1;
        exp_q[0].push_back(cyc + LAT);
        step(20);
        BTNA_raw = 1'b0;
        step(12);
        for (int ch = 0; ch < 2; ch++) begin
            checks++;
            if (obs_q[ch].size() != exp_q[ch].size()) begin
                fails++;
                $display("FAIL bounce ch%0d pulse_count: got %0d, expected %0d", ch, obs_q[ch].size(), exp_q[ch].size());
            end
            while (exp_q[ch].size() > 0 && obs_q[ch].size() > 0) begin
                e = exp_q[ch].pop_front();
                o = obs_q[ch].pop_front();
                checks++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL bounce ch%0d pulse_edge: got %0d, expected %0d", ch, o, e);
                end
            end
            exp_q[ch].delete();
            obs_q[ch].delete();
        end
    endtask

    task automatic test_simultaneous();
        int e, o;
        BTNA_raw = 1'b1;
        BTNB_raw = 1'b1;
        exp_q[0].push_back(cyc + LAT);
        exp_q[1].push_back(cyc + LAT);
        step(15);
        BTNA_raw = 1'b0;
        BTNB_raw = 1'b0;
        step(LAT - 1);
        checks++;
        if ({BTNA_level, BTNB_level} !== 2'b11) begin
            fails++;
            $display("FAIL simul level_hold: got %b, expected 11", {BTNA_level, BTNB_level});
        end
        step(1);
        checks++;
        if ({BTNA_level, BTNB_level} !== 2'b00) begin
            fails++;
            $display("FAIL simul level_release: got %b, expected 00", {BTNA_level, BTNB_level});
        end
        step(4);
        for (int ch = 0; ch < 2; ch++) begin
            checks++;
            if (obs_q[ch].size() != exp_q[ch].size()) begin
                fails++;
                $display("FAIL simul ch%0d pulse_count: got %0d, expected %0d", ch, obs_q[ch].size(), exp_q[ch].size());
            end
            while (exp_q[ch].size() > 0 && obs_q[ch].size() > 0) begin
                e = exp_q[ch].pop_front();
                o = obs_q[ch].pop_front();
                checks++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL simul ch%0d pulse_edge: got %0d, expected %0d", ch, o, e);
                end
            end
            exp_q[ch].delete();
            obs_q[ch].delete();
        end
    endtask

    task automatic test_reset_mid_press();
        int e, o, r;
        BTNA_raw = 1'b1;
        step(5);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({BTNA, BTNA_level} !== 2'b00) begin
            fails++;
            $display("FAIL rst_mid_press outputs: got %b, expected 00", {BTNA, BTNA_level});
        end
        step(4);
        rst = 1'b1;
        r = cyc;
        exp_q[0].push_back(r + LAT);
        while (cyc < r + LAT) step(1);
        // Pulse is high now; reset must clear it and the level without a clock edge
        rst = 1'b0;
        #1;
        checks++;
        if ({BTNA, BTNA_level} !== 2'b00) begin
            fails++;
            $display("FAIL rst_mid_pulse outputs: got %b, expected 00", {BTNA, BTNA_level});
        end
        step(3);
        rst = 1'b1;
        exp_q[0].push_back(cyc + LAT);
        step(12);
        BTNA_raw = 1'b0;
        step(12);
        for (int ch = 0; ch < 2; ch++) begin
            checks++;
            if (obs_q[ch].size() != exp_q[ch].size()) begin
                fails++;
                $display("FAIL rst_mid ch%0d pulse_count: got %0d, expected %0d", ch, obs_q[ch].size(), exp_q[ch].size());
            end
            while (exp_q[ch].size() > 0 && obs_q[ch].size() > 0) begin
                e = exp_q[ch].pop_front();
                o = obs_q[ch].pop_front();
                checks++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL rst_mid ch%0d pulse_edge: got %0d, expected %0d", ch, o, e);
                end
            end
            exp_q[ch].delete();
            obs_q[ch].delete();
        end
    endtask

    task automatic test_hold();
        int e, o, n;
        BTNB_raw = 1'b1;
        n = cyc + LAT;
        exp_q[1].push_back(n);
`ifdef BTN_AUTOREPEAT_EN
        exp_q[1].push_back(n + int'(RDELAY));
        for (int k = 1; n + int'(RDELAY) + k * int'(RPER) <= n + 40; k++)
            exp_q[1].push_back(n + int'(RDELAY) + k * int'(RPER));
`endif
        step(50);
        BTNB_raw = 1'b0;
        step(30);
        checks++;
        if (BTNB_level !== 1'b0) begin
            fails++;
            $display("FAIL hold level_after_release: got %b, expected 0", BTNB_level);
        end
        for (int ch = 0; ch < 2; ch++) begin
            checks++;
            if (obs_q[ch].size() != exp_q[ch].size()) begin
                fails++;
                $display("FAIL hold ch%0d pulse_count: got %0d, expected %0d", ch, obs_q[ch].size(), exp_q[ch].size());
            end
            while (exp_q[ch].size() > 0 && obs_q[ch].size() > 0) begin
                e = exp_q[ch].pop_front();
                o = obs_q[ch].pop_front();
                checks++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL hold ch%0d pulse_edge: got %0d, expected %0d", ch, o, e);
                end
            end
            exp_q[ch].delete();
            obs_q[ch].delete();
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid_press();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples needed to accept a level change; legal range 2..65535.
REQ-002 Parameter: REPEAT_DELAY, default 16, hold cycles before the first auto-repeat pulse (used only with BTN_AUTOREPEAT_EN).
REQ-003 Parameter: REPEAT_PERIOD, default 8, cycles between later auto-repeat pulses (used only with BTN_AUTOREPEAT_EN).
REQ-004 Port: clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-005 Port: rst, input, 1 bit, reset; asynchronous and active-low.
REQ-006 Port: BTNA_raw, input, 1 bit, asynchronous push-button A level, high = pressed.
REQ-007 Port: BTNB_raw, input, 1 bit, asynchronous push-button B level, high = pressed.
REQ-008 Port: BTNA, output, 1 bit, single-cycle press pulse for A; feeds the hockey game block's BTNA.
REQ-009 Port: BTNB, output, 1 bit, single-cycle press pulse for B; feeds the hockey game block's BTNB.
REQ-010 Port: BTNA_level, output, 1 bit, debounced level of A.
REQ-011 Port: BTNB_level, output, 1 bit, debounced level of B.

Function
REQ-012 Each channel (A, B) SHALL be an identical, independent instance; simultaneous activity on both channels SHALL NOT interact.
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer; the second flop's output is the sample s.
REQ-014 Each channel SHALL run a 4-state FSM: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, with counter cnt sized to hold DEBOUNCE_CYCLES.
REQ-015 IDLE: s=1 -> PRESS_WAIT with cnt=1; otherwise stay in IDLE.
REQ-016 PRESS_WAIT: s=0 -> IDLE with cnt=0; s=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED; s=1 otherwise -> cnt+1.
REQ-017 PRESSED: s=0 -> RELEASE_WAIT with cnt=1; otherwise stay.
REQ-018 RELEASE_WAIT: s=1 -> PRESSED with cnt=0; s=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE; s=0 otherwise -> cnt+1.
REQ-019 The pulse output SHALL be registered and high for exactly one cycle, on the transition PRESS_WAIT->PRESSED.
REQ-020 Press latency: the pulse SHALL be high after rising edge DEBOUNCE_CYCLES+2, counting edge 1 as the first edge that samples raw high, provided raw stays high.
REQ-021 The level output SHALL be registered: it goes high together with the pulse and goes low on the transition RELEASE_WAIT->IDLE.
REQ-022 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no pulse and no level change.
REQ-023 Holding a button indefinitely SHALL produce exactly one pulse unless BTN_AUTOREPEAT_EN is defined.
REQ-024 The counter SHALL never wrap; it is bounded by the transitions above.

Reset
REQ-025 While rst=0, all of the following SHALL be 0 immediately, without waiting for a clock edge: synchronizer flops, FSM (IDLE), cnt, BTNA, BTNB, BTNA_level, BTNB_level.
REQ-026 Reset asserted mid-debounce or mid-pulse SHALL abort the operation; no pulse SHALL appear during reset.
REQ-027 If a button is held across reset release, it SHALL go through the full debounce and emit one pulse.

Configuration
REQ-028 Macro BTN_AUTOREPEAT_EN, defined: in PRESSED with s=1, a hold counter SHALL emit an extra one-cycle pulse REPEAT_DELAY cycles after the initial pulse, then one every REPEAT_PERIOD cycles until release.
REQ-029 Macro BTN_AUTOREPEAT_EN, undefined: no hold counter SHALL exist, and behaviour SHALL be exactly REQ-012..REQ-027.

Verification
REQ-030 Clean press: DEBOUNCE_CYCLES=4, BTNA_raw 0->1 held 30 cycles -> BTNA high for one cycle after edge 6; BTNA_level high from the same edge; BTNB stays 0.
REQ-031 Glitch: BTNA_raw high for 2 cycles, then low -> BTNA and BTNA_level remain 0 throughout.
REQ-032 Bounce: BTNA_raw toggles every cycle for 10 cycles, then holds high -> exactly one BTNA pulse, 6 edges after the final rising transition.
REQ-033 Simultaneous: BTNA_raw and BTNB_raw rise on the same cycle -> BTNA and BTNB pulse on the same cycle; on release, both levels drop 6 edges after raw falls.
REQ-034 Reset mid-press: rst=0 asserted at cycle 3 of PRESS_WAIT with raw held high -> outputs 0 immediately; after rst=1, one pulse 6 edges later.
REQ-035 Auto-repeat (macro defined): BTNB_raw held 50 cycles -> pulses at initial edge N, N+16, N+24, N+32, N+40; no further pulses after release.
